// File: rtl/periph_bus_pkg.sv
// Shared types and default address map for the CPU-to-peripheral bus fabric.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package periph_bus_pkg;

  // Fabric transaction states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Slot index width; one extra code so DEFAULT_SLV == NUM_SLV (decode error) is representable
  function automatic int slot_w(input int num_slv);
    return $clog2(num_slv + 1);
  endfunction

  // Default RV32I system map: 4 KiB windows for MEM/TIMER/UART/GPIO
  localparam logic [31:0] MEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'h0000_1000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;
  localparam logic [31:0] UART_BASE  = 32'h0000_2000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE  = 32'h0000_3000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;

  // Packed default tables, slot 0 in the low bits
  localparam logic [127:0] DEF_SLV_BASE = {GPIO_BASE, UART_BASE, TIMER_BASE, MEM_BASE};
  localparam logic [127:0] DEF_SLV_MASK = {GPIO_MASK, UART_MASK, TIMER_MASK, MEM_MASK};

endpackage

// File: rtl/periph_bus_fabric_addr_decode.sv
// Priority base/mask address decoder: lowest-index matching window wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle regardless of request state.
module periph_addr_decode #(
  parameter int                   NUM_SLV  = 4,
  parameter int                   AW       = 32,
  parameter int                   SLOT_W   = 3,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW-1:0]     addr,
  output logic [SLOT_W-1:0] slot,
  output logic              hit
);

  // Scan from the top slot down so the lowest matching index is the last write
  always_comb begin
    slot = '0;
    hit  = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        slot = SLOT_W'(i);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// CPU data-bus fabric: decodes an access, strobes one peripheral slot, returns data/done/error.
// Latency: strobes 1 cycle after request, done 1 cycle after slot ready; decode error done in 1 cycle.
// Backpressure: waits in ACCESS on the selected slot's s_ready; with BUS_TIMEOUT_EN, gives up after TO_CYCLES.
module periph_bus_fabric
  import periph_bus_pkg::*;
#(
  parameter int                    NUM_SLV     = 4,
  parameter int                    AW          = 32,
  parameter int                    DW          = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE    = DEF_SLV_BASE,
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK    = DEF_SLV_MASK,
  parameter int                    DEFAULT_SLV = 0,
  parameter int                    TO_CYCLES   = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AW-1:0]         m_addr,
  input  logic                  m_re,
  input  logic                  m_we,
  input  logic [DW/8-1:0]       m_be,
  input  logic [DW-1:0]         m_wdata,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_cs_n,
  output logic                  s_rd_n,
  output logic                  s_wr_n,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_be,
  input  logic [NUM_SLV*DW-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_ready
);

  localparam int SLOT_W      = slot_w(NUM_SLV);
  localparam int BW          = DW / 8;
  localparam bit MISS_IS_ERR = (DEFAULT_SLV >= NUM_SLV);

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W_RAW = $clog2(TO_CYCLES + 1);
  localparam int TO_W     = (TO_W_RAW < 8) ? 8 : ((TO_W_RAW > 16) ? 16 : TO_W_RAW);
  logic [TO_W-1:0] cnt_q, cnt_d;
`else
  // TO_CYCLES has no meaning when ACCESS waits indefinitely
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES == 0);
`endif

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                op_wr_q, op_wr_d;
  logic [AW-1:0]       s_addr_q, s_addr_d;
  logic [DW-1:0]       s_wdata_q, s_wdata_d;
  logic [BW-1:0]       s_be_q, s_be_d;
  logic [NUM_SLV-1:0]  cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic [DW-1:0]       m_rdata_q, m_rdata_d;
  logic                m_ready_q, m_ready_d;
  logic                m_err_q, m_err_d;

  logic [SLOT_W-1:0]   dec_slot;
  logic                dec_hit;
  logic [SLOT_W-1:0]   sel_slot;
  logic                miss_err;
  logic [NUM_SLV-1:0]  sel_cs_n;
  logic                rdy_sel;
  logic [DW-1:0]       rdata_sel;

  periph_addr_decode #(
    .NUM_SLV  (NUM_SLV),
    .AW       (AW),
    .SLOT_W   (SLOT_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (m_addr),
    .slot (dec_slot),
    .hit  (dec_hit)
  );

  // Resolve the target slot for a new request and its active-low chip-select pattern
  always_comb begin
    sel_slot = dec_hit ? dec_slot : SLOT_W'(DEFAULT_SLV);
    miss_err = !dec_hit && MISS_IS_ERR;
    sel_cs_n = '1;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_slot == SLOT_W'(i)) begin
        sel_cs_n[i] = 1'b0;
      end
    end
  end

  // Pick ready and read data of the latched slot only; other slots are ignored
  always_comb begin
    rdy_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        rdy_sel   = s_ready[i];
        rdata_sel = s_rdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic for IDLE -> ACCESS -> RESP
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    op_wr_d   = op_wr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    m_rdata_d = m_rdata_q;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m_re || m_we) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_be_d    = m_be;
          op_wr_d   = m_we;
          slot_d    = sel_slot;
          if (miss_err) begin
            // Unmapped address: answer immediately, never touch a peripheral
            state_d   = RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cs_n_d  = sel_cs_n;
            rd_n_d  = m_we;
            wr_n_d  = !m_we;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (rdy_sel) begin
          cs_n_d    = '1;
          rd_n_d    = 1'b1;
          wr_n_d    = 1'b1;
          state_d   = RESP;
          m_ready_d = 1'b1;
          if (!op_wr_q) begin
            m_rdata_d = rdata_sel;
          end
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == TO_W'(TO_CYCLES - 1)) begin
          // Slot never answered: abort with an error and clear read data
          cs_n_d    = '1;
          rd_n_d    = 1'b1;
          wr_n_d    = 1'b1;
          state_d   = RESP;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops every strobe asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      op_wr_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      cs_n_q    <= '1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      m_rdata_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      op_wr_q   <= op_wr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      m_rdata_q <= m_rdata_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign m_rdata = m_rdata_q;
  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign s_cs_n  = cs_n_q;
  assign s_rd_n  = rd_n_q;
  assign s_wr_n  = wr_n_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_be    = s_be_q;

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Directed bench for periph_bus_fabric with a completion scoreboard.
// Latency: checks strobe and done timing cycle by cycle against a bench-side model.
// Backpressure: drives per-slot s_ready delays, including never-ready (timeout or hang).
module tb_periph_bus_fabric;

  localparam int NS = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [31:0]     m_addr;
  logic            m_re, m_we;
  logic [3:0]      m_be;
  logic [31:0]     m_wdata;
  logic [31:0]     m_rdata;
  logic            m_ready, m_err;
  logic [NS-1:0]   s_cs_n;
  logic            s_rd_n, s_wr_n;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_be;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]   s_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  // Slot 3 covers 0x0000-0xFFFF and overlaps slots 0..2; misses are decode errors
  periph_bus_fabric #(
    .NUM_SLV     (NS),
    .AW          (32),
    .DW          (32),
    .SLV_BASE    ({32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLV_MASK    ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .DEFAULT_SLV (NS),
    .TO_CYCLES   (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_addr  (m_addr),
    .m_re    (m_re),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_err   (m_err),
    .s_cs_n  (s_cs_n),
    .s_rd_n  (s_rd_n),
    .s_wr_n  (s_wr_n),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_be    (s_be),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot_data(input int s);
    return 32'hA5A5_0000 + 32'(s);
  endfunction

  // kind: 0 normal completion, 1 decode error, 2 timeout
  task automatic access(input logic [31:0] addr, input logic re, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input int slot, input int kind, input int wait_n, input bit hold);
    int          lat;
    exp_t        e;
    exp_t        got;
    logic [3:0]  one;
    logic [3:0]  exp_cs;
    one    = 4'b0001;
    exp_cs = ~(one << slot);
    lat    = (kind == 1) ? 1 : ((kind == 2) ? TO + 1 : wait_n + 2);
    if (kind == 2) model_rdata = '0;
    else if (kind == 0 && !we) model_rdata = slot_data(slot);
    e.rdata = model_rdata;
    e.err   = (kind != 0);
    exp_q.push_back(e);

    @(posedge clk); #1;
    m_addr = addr; m_re = re; m_we = we; m_be = be; m_wdata = wdata;
    s_ready = '1;
    if (kind != 1) s_ready[slot] = (wait_n == 0);
    @(negedge clk);
    chk("c0_cs_idle", 32'(s_cs_n), 32'hF);
    chk("c0_no_done", 32'(m_ready), 0);

    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      // Fields must already be latched; scramble them to prove it
      m_addr = $urandom; m_wdata = $urandom; m_be = 4'($urandom);
      if (kind != 1) s_ready[slot] = (cyc >= wait_n + 1);
      @(negedge clk);
      if (cyc < lat) begin
        chk("acc_cs", 32'(s_cs_n), 32'(exp_cs));
        chk("acc_rd_n", 32'(s_rd_n), 32'(we));
        chk("acc_wr_n", 32'(s_wr_n), 32'(!we));
        chk("acc_addr", s_addr, addr);
        chk("acc_wdata", s_wdata, wdata);
        chk("acc_be", 32'(s_be), 32'(be));
        chk("acc_no_done", 32'(m_ready), 0);
      end else begin
        chk("resp_done", 32'(m_ready), 1);
        chk("resp_cs_rel", 32'(s_cs_n), 32'hF);
        chk("resp_rd_rel", 32'(s_rd_n), 1);
        chk("resp_wr_rel", 32'(s_wr_n), 1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("sb_rdata", m_rdata, got.rdata);
          chk("sb_err", 32'(m_err), 32'(got.err));
        end
        if (!hold) begin
          m_re = 1'b0;
          m_we = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int  n_wait;
    bit  seen_done;
    reset_n = 1'b0;
    m_addr = '0; m_re = 1'b0; m_we = 1'b0; m_be = '0; m_wdata = '0;
    s_ready = '1;
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = slot_data(i);
    model_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cs", 32'(s_cs_n), 32'hF);
    chk("rst_rd_n", 32'(s_rd_n), 1);
    chk("rst_wr_n", 32'(s_wr_n), 1);
    chk("rst_ready", 32'(m_ready), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    chk("rst_be", 32'(s_be), 0);

    // T1: read slot 1 with ready tied high (slot 3 overlaps, lower index wins)
    access(32'h0000_1004, 1'b1, 1'b0, 4'hF, 32'h0, 1, 0, 0, 1'b0);
    // T2: write to slot 2 with three wait cycles; m_rdata must hold
    access(32'h0000_2010, 1'b0, 1'b1, 4'b0011, 32'hCAFE_F00D, 2, 0, 3, 1'b0);
    // Read and write both high: write wins, slot 0 beats overlapping slot 3
    access(32'h0000_0010, 1'b1, 1'b1, 4'b1100, 32'h1234_5678, 0, 0, 1, 1'b0);
    // T3: unmapped read and write are decode errors, m_rdata unchanged
    access(32'h8000_0000, 1'b1, 1'b0, 4'hF, 32'h0, 0, 1, 0, 1'b0);
    access(32'h0001_0000, 1'b0, 1'b1, 4'hF, 32'h5555_AAAA, 0, 1, 0, 1'b0);
    // T6: back-to-back reads with request held; second goes to slot 3 only
    access(32'h0000_1008, 1'b1, 1'b0, 4'hF, 32'h0, 1, 0, 0, 1'b1);
    access(32'h0000_5000, 1'b1, 1'b0, 4'hF, 32'h0, 3, 0, 2, 1'b1);
    access(32'h0000_0004, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0, 0, 1'b0);

`ifdef BUS_TIMEOUT_EN
    // T4: slot never answers, fabric aborts after TO access cycles
    access(32'h0000_2000, 1'b1, 1'b0, 4'hF, 32'h0, 2, 2, 1_000_000, 1'b0);
    n_wait = 3;
`else
    n_wait = 1000;
`endif

    // T4 without timeout / T5: hang in ACCESS, then reset mid-access
    @(posedge clk); #1;
    m_addr = 32'h0000_2008; m_re = 1'b1; m_we = 1'b0; m_be = 4'hF;
    s_ready = 4'b1011;
    seen_done = 1'b0;
    repeat (n_wait) begin
      @(negedge clk);
      if (m_ready === 1'b1) seen_done = 1'b1;
    end
    chk("hang_cs", 32'(s_cs_n), 32'b1011);
    chk("hang_rd_n", 32'(s_rd_n), 0);
    chk("hang_no_done", 32'(seen_done), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cs", 32'(s_cs_n), 32'hF);
    chk("arst_rd_n", 32'(s_rd_n), 1);
    chk("arst_wr_n", 32'(s_wr_n), 1);
    m_re = 1'b0;
    model_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_done", 32'(m_ready), 0);
      chk("post_rst_cs", 32'(s_cs_n), 32'hF);
      chk("post_rst_rdata", m_rdata, 0);
    end
    // Fabric is back in IDLE and serves a fresh read
    access(32'h0000_1FFC, 1'b1, 1'b0, 4'hF, 32'h0, 1, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
